// File: rtl/herzel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : herzel_pkg
// Purpose : Types and constants shared by the Herzel bank, the bin collector
//           and the register/readout block.
//   - herzel_state_e : bin collector FSM state encoding
//   - HERZEL_NF_DEF  : default number of frequency bins
//   - HERZEL_DW_DEF  : default signed bin data width
//   - herzel_bins_t  : packed bin array at the default sizes
// Revision: 1.0 - initial release
// ============================================================================
package herzel_pkg;

  localparam int HERZEL_NF_DEF = 11;
  localparam int HERZEL_DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_STREAM = 2'd3
  } herzel_state_e;

  typedef logic signed [HERZEL_NF_DEF-1:0][HERZEL_DW_DEF-1:0] herzel_bins_t;

endpackage
`default_nettype wire

// File: rtl/herzel_abs_cmp.sv
`default_nettype none
// ============================================================================
// Module  : herzel_abs_cmp
// Purpose : Combinational magnitude of a signed bin value plus a strict
//           greater-than against the running peak magnitude.
// Ports   :
//   x_i    in  DW  signed bin value
//   peak_i in  DW  unsigned running peak magnitude
//   mag_o  out DW  unsigned |x_i|
//   gt_o   out 1   |x_i| > peak_i (strict)
// Revision: 1.0 - initial release
// ============================================================================
module herzel_abs_cmp
  import herzel_pkg::*;
#(
  parameter int DW = HERZEL_DW_DEF
) (
  input  logic signed [DW-1:0] x_i,
  input  logic        [DW-1:0] peak_i,
  output logic        [DW-1:0] mag_o,
  output logic                 gt_o
);

  // One extra bit so that negating the most negative value cannot overflow;
  // its magnitude 2^(DW-1) still fits the unsigned DW-bit output.
  logic signed [DW:0] x_ext;
  logic        [DW:0] mag_ext;

  always_comb begin
    x_ext   = {x_i[DW-1], x_i};
    mag_ext = x_ext[DW] ? $unsigned(-x_ext) : $unsigned(x_ext);
    mag_o   = mag_ext[DW-1:0];
    gt_o    = (mag_ext > {1'b0, peak_i});
  end

endmodule
`default_nettype wire

// File: rtl/herzel_bin_collector.sv
`default_nettype none
// ============================================================================
// Module  : herzel_bin_collector
// Purpose : Captures NF per-bin Herzel results into a frame buffer, optionally
//           finds the peak-magnitude bin, then streams the bins out one per
//           beat over valid/ready.
// Config  : HERZEL_PEAK_SEARCH_EN - when defined, adds the SCAN state, the
//           magnitude comparator and the peak registers. Otherwise the peak
//           outputs are tied to zero and FILL goes straight to STREAM.
// Ports   :
//   clk, rst            clock, asynchronous active-high reset
//   clr_i               synchronous abort (back to IDLE, clears flags/overrun)
//   valid_i [NF]        per-bin result-valid pulses
//   data_i  [NF][DW]    per-bin signed results
//   m_valid_o/m_ready_i output beat handshake
//   m_data_o, m_idx_o   bin value and index of the current beat
//   m_last_o            high on the beat with index NF-1
//   busy_o              high outside IDLE
//   frame_done_o        one-cycle pulse after the last beat is accepted
//   overrun_o           sticky: a bin arrived while the buffer was locked
//   peak_idx_o/mag_o    index and |value| of the largest bin
// Revision: 1.0 - initial release
// ============================================================================
module herzel_bin_collector
  import herzel_pkg::*;
#(
  parameter  int NF = HERZEL_NF_DEF,
  parameter  int DW = HERZEL_DW_DEF,
  localparam int IW = $clog2(NF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic [NF-1:0]               valid_i,
  input  logic signed [NF-1:0][DW-1:0] data_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [DW-1:0]               m_data_o,
  output logic [IW-1:0]               m_idx_o,
  output logic                        m_last_o,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        overrun_o,
  output logic [IW-1:0]               peak_idx_o,
  output logic [DW-1:0]               peak_mag_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);

  herzel_state_e         state_q, state_d;
  logic [NF-1:0]         got_q, got_d;
  logic [NF-1:0][DW-1:0] buf_q, buf_d;
  logic                  m_valid_q, m_valid_d;
  logic [DW-1:0]         m_data_q, m_data_d;
  logic [IW-1:0]         m_idx_q, m_idx_d;
  logic                  m_last_q, m_last_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;

`ifdef HERZEL_PEAK_SEARCH_EN
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic [DW-1:0] run_mag_q, run_mag_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic [IW-1:0] peak_idx_q, peak_idx_d;
  logic [DW-1:0] peak_mag_q, peak_mag_d;
  logic [DW-1:0] cmp_mag;
  logic          cmp_gt;
  logic          take;

  herzel_abs_cmp #(
    .DW (DW)
  ) u_abs_cmp (
    .x_i    (buf_q[scan_idx_q]),
    .peak_i (run_mag_q),
    .mag_o  (cmp_mag),
    .gt_o   (cmp_gt)
  );
`endif

  always_comb begin
    state_d      = state_q;
    got_d        = got_q;
    buf_d        = buf_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_idx_d      = m_idx_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
`ifdef HERZEL_PEAK_SEARCH_EN
    scan_idx_d   = scan_idx_q;
    run_mag_d    = run_mag_q;
    run_idx_d    = run_idx_q;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    // Bin 0 seeds the running peak; afterwards only a strictly larger
    // magnitude replaces it, so ties keep the lowest index.
    take         = (scan_idx_q == '0) || cmp_gt;
`endif

    if (clr_i) begin
      // Abort wins over any same-cycle valid_i; peak results are kept.
      state_d   = ST_IDLE;
      got_d     = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      m_idx_d   = '0;
      m_last_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FILL: begin
          for (int k = 0; k < NF; k++) begin
            if (valid_i[k]) begin
              buf_d[k] = data_i[k];
              got_d[k] = 1'b1;
            end
          end
          if (&got_d) begin
`ifdef HERZEL_PEAK_SEARCH_EN
            state_d    = ST_SCAN;
            scan_idx_d = '0;
`else
            // buf_d forwards a bin 0 written on this very edge.
            state_d   = ST_STREAM;
            m_valid_d = 1'b1;
            m_idx_d   = '0;
            m_data_d  = buf_d[0];
            m_last_d  = 1'b0;
`endif
          end else if (|got_d) begin
            state_d = ST_FILL;
          end
        end

`ifdef HERZEL_PEAK_SEARCH_EN
        ST_SCAN: begin
          if (|valid_i) begin
            overrun_d = 1'b1;
          end
          run_mag_d = take ? cmp_mag    : run_mag_q;
          run_idx_d = take ? scan_idx_q : run_idx_q;
          if (scan_idx_q == LAST_IDX) begin
            peak_mag_d = run_mag_d;
            peak_idx_d = run_idx_d;
            state_d    = ST_STREAM;
            m_valid_d  = 1'b1;
            m_idx_d    = '0;
            m_data_d   = buf_q[0];
            m_last_d   = 1'b0;
          end else begin
            scan_idx_d = scan_idx_q + IW'(1);
          end
        end
`endif

        ST_STREAM: begin
          if (|valid_i) begin
            overrun_d = 1'b1;
          end
          if (m_ready_i) begin
            if (m_last_q) begin
              state_d      = ST_IDLE;
              got_d        = '0;
              m_valid_d    = 1'b0;
              m_data_d     = '0;
              m_idx_d      = '0;
              m_last_d     = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              m_idx_d  = m_idx_q + IW'(1);
              m_data_d = buf_q[m_idx_d];
              m_last_d = (m_idx_d == LAST_IDX);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      got_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_idx_q      <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef HERZEL_PEAK_SEARCH_EN
      scan_idx_q   <= '0;
      run_mag_q    <= '0;
      run_idx_q    <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      got_q        <= got_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_idx_q      <= m_idx_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef HERZEL_PEAK_SEARCH_EN
      scan_idx_q   <= scan_idx_d;
      run_mag_q    <= run_mag_d;
      run_idx_q    <= run_idx_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
`endif
    end
  end

  // Buffer contents are qualified by got_q, so they need no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_idx_o      = m_idx_q;
  assign m_last_o     = m_last_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;
`ifdef HERZEL_PEAK_SEARCH_EN
  assign peak_idx_o   = peak_idx_q;
  assign peak_mag_o   = peak_mag_q;
`else
  assign peak_idx_o   = '0;
  assign peak_mag_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_herzel_bin_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_herzel_bin_collector
// Purpose : Directed self-checking bench for herzel_bin_collector, NF=4,
//           DW=32. Expected latency and peak values follow
//           HERZEL_PEAK_SEARCH_EN so the same bench covers both builds.
// Revision: 1.0 - initial release
// ============================================================================
module tb_herzel_bin_collector;

  localparam int NF = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef HERZEL_PEAK_SEARCH_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif
  // Edges after the capture of the final bin before m_valid_o is seen.
  localparam int WAIT_EXP = PEAK_ON ? NF : 0;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         clr_i;
  logic [NF-1:0]                valid_i;
  logic signed [NF-1:0][DW-1:0] data_i;
  logic                         m_valid_o;
  logic                         m_ready_i;
  logic [DW-1:0]                m_data_o;
  logic [IW-1:0]                m_idx_o;
  logic                         m_last_o;
  logic                         busy_o;
  logic                         frame_done_o;
  logic                         overrun_o;
  logic [IW-1:0]                peak_idx_o;
  logic [DW-1:0]                peak_mag_o;

  int checks = 0;
  int errors = 0;

  herzel_bin_collector #(
    .NF (NF),
    .DW (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_idx_o      (m_idx_o),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o),
    .peak_idx_o   (peak_idx_o),
    .peak_mag_o   (peak_mag_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle of bin delivery, then valid_i is dropped.
  task automatic drive(input logic [NF-1:0] v, input logic signed [DW-1:0] d0,
                       input logic signed [DW-1:0] d1, input logic signed [DW-1:0] d2,
                       input logic signed [DW-1:0] d3);
    valid_i   = v;
    data_i[0] = d0;
    data_i[1] = d1;
    data_i[2] = d2;
    data_i[3] = d3;
    tick();
    valid_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr_i = 1'b0; valid_i = '0; data_i = '0; m_ready_i = 1'b0;
    tick(); tick();
    checks++;
    if ({m_valid_o, m_last_o, busy_o, frame_done_o, overrun_o} !== 5'b0 ||
        m_data_o !== '0 || m_idx_o !== '0) begin
      errors++;
      $display("FAIL reset_stream valid=%b last=%b busy=%b done=%b ovr=%b data=%0h idx=%0d required all 0",
               m_valid_o, m_last_o, busy_o, frame_done_o, overrun_o, m_data_o, m_idx_o);
    end
    checks++;
    if (peak_idx_o !== '0 || peak_mag_o !== '0) begin
      errors++;
      $display("FAIL reset_peak idx=%0d mag=%0h required 0/0", peak_idx_o, peak_mag_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_in_order_fill;
    logic signed [DW-1:0] exp [NF];
    int n;
    exp = '{32'sd5, -32'sd9, 32'sd3, 32'sd7};
    m_ready_i = 1'b1;
    drive(4'b0001, exp[0], 0, 0, 0);
    drive(4'b0010, 0, exp[1], 0, 0);
    drive(4'b0100, 0, 0, exp[2], 0);
    drive(4'b1000, 0, 0, 0, exp[3]);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != WAIT_EXP) begin
      errors++;
      $display("FAIL inorder_latency edges=%0d required=%0d", n, WAIT_EXP);
    end
    for (int i = 0; i < NF; i++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IW'(i) || m_data_o !== exp[i] ||
          m_last_o !== (i == NF - 1) || frame_done_o !== 1'b0) begin
        errors++;
        $display("FAIL inorder_beat%0d valid=%b idx=%0d data=%0d last=%b done=%b required 1/%0d/%0d/%b/0",
                 i, m_valid_o, m_idx_o, $signed(m_data_o), m_last_o, frame_done_o, i, exp[i], (i == NF - 1));
      end
      tick();
    end
    checks++;
    if (frame_done_o !== 1'b1 || m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL inorder_done done=%b valid=%b busy=%b required 1/0/0", frame_done_o, m_valid_o, busy_o);
    end
    checks++;
    if (peak_idx_o !== (PEAK_ON ? 2'd1 : 2'd0) || peak_mag_o !== (PEAK_ON ? 32'd9 : 32'd0)) begin
      errors++;
      $display("FAIL inorder_peak idx=%0d mag=%0d required %0d/%0d", peak_idx_o, peak_mag_o,
               PEAK_ON ? 1 : 0, PEAK_ON ? 9 : 0);
    end
    tick();
    checks++;
    if (frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL inorder_done_pulse done=%b required 0", frame_done_o);
    end
  endtask

  task automatic test_simultaneous_tie;
    logic signed [DW-1:0] exp [NF];
    int n;
    exp = '{-32'sd7, 32'sd7, 32'sd2, 32'sd7};
    m_ready_i = 1'b1;
    drive(4'b1111, exp[0], exp[1], exp[2], exp[3]);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != WAIT_EXP) begin
      errors++;
      $display("FAIL tie_latency edges=%0d required=%0d", n, WAIT_EXP);
    end
    for (int i = 0; i < NF; i++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IW'(i) || m_data_o !== exp[i]) begin
        errors++;
        $display("FAIL tie_beat%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                 i, m_valid_o, m_idx_o, $signed(m_data_o), i, exp[i]);
      end
      tick();
    end
    checks++;
    if (peak_idx_o !== 2'd0 || peak_mag_o !== (PEAK_ON ? 32'd7 : 32'd0)) begin
      errors++;
      $display("FAIL tie_peak idx=%0d mag=%0d required 0/%0d", peak_idx_o, peak_mag_o, PEAK_ON ? 7 : 0);
    end
    // Most negative value: magnitude 2^31 must survive the abs step.
    drive(4'b1111, 32'sh8000_0000, 0, 0, 0);
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin tick(); n++; end
    tick();
    checks++;
    if (peak_idx_o !== 2'd0 || peak_mag_o !== (PEAK_ON ? 32'h8000_0000 : 32'd0)) begin
      errors++;
      $display("FAIL minval_peak idx=%0d mag=%0h required 0/%0h", peak_idx_o, peak_mag_o,
               PEAK_ON ? 32'h8000_0000 : 32'd0);
    end
  endtask

  task automatic test_backpressure;
    logic signed [DW-1:0] exp [NF];
    logic [3:0] pat;
    int n, ei, c;
    bit done;
    exp = '{32'sd11, -32'sd22, 32'sd33, -32'sd44};
    pat = 4'b1001;
    m_ready_i = 1'b0;
    drive(4'b1111, exp[0], exp[1], exp[2], exp[3]);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    ei = 0; c = 0; done = 1'b0;
    while (!done && c < 40) begin
      m_ready_i = pat[c % 4];
      checks++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IW'(ei) || m_data_o !== exp[ei] ||
          m_last_o !== (ei == NF - 1) || frame_done_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_cycle%0d valid=%b idx=%0d data=%0d last=%b done=%b required 1/%0d/%0d/%b/0",
                 c, m_valid_o, m_idx_o, $signed(m_data_o), m_last_o, frame_done_o, ei, exp[ei], (ei == NF - 1));
      end
      if (m_ready_i) begin
        if (ei == NF - 1) done = 1'b1;
        else ei++;
      end
      tick();
      c++;
    end
    m_ready_i = 1'b0;
    checks++;
    if (!done || frame_done_o !== 1'b1 || m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done finished=%b done=%b valid=%b required 1/1/0", done, frame_done_o, m_valid_o);
    end
    checks++;
    if (peak_idx_o !== (PEAK_ON ? 2'd3 : 2'd0) || peak_mag_o !== (PEAK_ON ? 32'd44 : 32'd0)) begin
      errors++;
      $display("FAIL bp_peak idx=%0d mag=%0d required %0d/%0d", peak_idx_o, peak_mag_o,
               PEAK_ON ? 3 : 0, PEAK_ON ? 44 : 0);
    end
    tick();
  endtask

  task automatic test_overwrite_overrun;
    logic signed [DW-1:0] exp [NF];
    int n;
    exp = '{32'sd20, 32'sd1, 32'sd2, 32'sd3};
    m_ready_i = 1'b0;
    drive(4'b0001, 32'sd10, 0, 0, 0);
    drive(4'b0001, 32'sd20, 0, 0, 0);
    drive(4'b1110, 32'sd99, exp[1], exp[2], exp[3]);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (overrun_o !== 1'b0 || m_data_o !== exp[0]) begin
      errors++;
      $display("FAIL overwrite ovr=%b data=%0d required 0/20", overrun_o, $signed(m_data_o));
    end
    drive(4'b0100, 0, 0, 32'sd555, 0);
    checks++;
    if (overrun_o !== 1'b1 || m_idx_o !== 2'd0 || m_data_o !== exp[0]) begin
      errors++;
      $display("FAIL overrun_set ovr=%b idx=%0d data=%0d required 1/0/20", overrun_o, m_idx_o, $signed(m_data_o));
    end
    m_ready_i = 1'b1;
    for (int i = 0; i < NF; i++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IW'(i) || m_data_o !== exp[i]) begin
        errors++;
        $display("FAIL ovr_beat%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                 i, m_valid_o, m_idx_o, $signed(m_data_o), i, exp[i]);
      end
      tick();
    end
    m_ready_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b1 || frame_done_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky ovr=%b done=%b required 1/1", overrun_o, frame_done_o);
    end
    checks++;
    if (peak_idx_o !== 2'd0 || peak_mag_o !== (PEAK_ON ? 32'd20 : 32'd0)) begin
      errors++;
      $display("FAIL ovr_peak idx=%0d mag=%0d required 0/%0d", peak_idx_o, peak_mag_o, PEAK_ON ? 20 : 0);
    end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear ovr=%b required 0", overrun_o);
    end
  endtask

  task automatic test_abort;
    logic signed [DW-1:0] exp [NF];
    int n;
    m_ready_i = 1'b1;
    drive(4'b1111, 32'sd1, -32'sd2, 32'sd3, -32'sd4);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (m_idx_o !== 2'd2 || m_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_pos idx=%0d valid=%b required 2/1", m_idx_o, m_valid_o);
    end
    // valid_i raised together with clr_i must be ignored.
    clr_i = 1'b1;
    valid_i = 4'b0001;
    tick();
    clr_i = 1'b0;
    valid_i = '0;
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state valid=%b busy=%b done=%b ovr=%b required 0/0/0/0",
               m_valid_o, busy_o, frame_done_o, overrun_o);
    end
    checks++;
    if (peak_idx_o !== (PEAK_ON ? 2'd3 : 2'd0) || peak_mag_o !== (PEAK_ON ? 32'd4 : 32'd0)) begin
      errors++;
      $display("FAIL abort_peak_hold idx=%0d mag=%0d required %0d/%0d", peak_idx_o, peak_mag_o,
               PEAK_ON ? 3 : 0, PEAK_ON ? 4 : 0);
    end
    exp = '{32'sd6, 32'sd7, 32'sd8, 32'sd9};
    drive(4'b1111, exp[0], exp[1], exp[2], exp[3]);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    for (int i = 0; i < NF; i++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IW'(i) || m_data_o !== exp[i]) begin
        errors++;
        $display("FAIL abort_next_beat%0d valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                 i, m_valid_o, m_idx_o, $signed(m_data_o), i, exp[i]);
      end
      tick();
    end
    checks++;
    if (frame_done_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_done done=%b required 1", frame_done_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream;
    int n;
    m_ready_i = 1'b0;
    drive(4'b1111, 32'sd5, 32'sd6, 32'sd7, 32'sd8);
    n = 0;
    while (m_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || m_data_o !== '0 || peak_mag_o !== '0) begin
      errors++;
      $display("FAIL async_reset valid=%b busy=%b data=%0d pmag=%0d required 0/0/0/0",
               m_valid_o, busy_o, m_data_o, peak_mag_o);
    end
    tick();
    rst = 1'b0;
    m_ready_i = 1'b1;
    tick(); tick();
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume valid=%b busy=%b required 0/0", m_valid_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_in_order_fill();
    test_simultaneous_tie();
    test_backpressure();
    test_overwrite_overrun();
    test_abort();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
